ps2_scan_receiver: RTL and testbench

Parametrised PS/2 keyboard receiver with a glitch filter on the PS/2 clock, full frame checking (start bit, odd parity, stop bit), a bit-timeout watchdog, E0/F0 prefix decoding and a show-ahead receive FIFO. It sits between the PS/2 pins and the CPU-side memory/IO logic. It replaces single-byte, unchecked capture with buffered, tagged scan codes and error reporting.

---
 rtl/ps2_scan_receiver.sv | 193 +++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: glitch-filtered clock, framed byte checking,
// bit watchdog, E0/F0 prefix tagging and a show-ahead scan-code FIFO.
module ps2_scan_receiver #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  input  logic                          rd_en,
  output logic [9:0]                    dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYC);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  state_t            state, state_n;
  logic [FILTER_LEN-1:0] filt;
  logic              f, f_next, fall;
  logic [10:0]       b;
  logic [3:0]        bcnt;
  logic [TW-1:0]     tcnt;
  logic              ext_pend, brk_pend;
  logic              push, pop, wr, timeout;
  logic              bad_frame, bad_par;
  logic [7:0]        code;
  logic [9:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;

  assign code = b[8:1];

  // Filtered clock only moves when every sample agrees
  always_comb begin
    f_next = f;
    if (&filt)
      f_next = 1'b1;
    else if (~|filt)
      f_next = 1'b0;
  end

  assign fall = f & ~f_next;

  // Sample ps2c and hold the filtered level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= '0;
      f    <= 1'b0;
    end else begin
      filt <= {filt[FILTER_LEN-2:0], ps2c};
      f    <= f_next;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next state, frame checks and error pulses
  always_comb begin
    state_n    = state;
    timeout    = 1'b0;
    bad_frame  = b[0] | ~b[10];
    bad_par    = ~^b[9:1];
    frame_err  = 1'b0;
    parity_err = 1'b0;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall && rx_en)
          state_n = RECV;
      end
      RECV: begin
        if (fall) begin
          if (bcnt == 4'd0)
            state_n = CHECK;
        end else if (tcnt == TMAX) begin
          state_n   = IDLE;
          timeout   = 1'b1;
          frame_err = 1'b1;
        end
      end
      CHECK: begin
        state_n    = IDLE;
        frame_err  = bad_frame;
        parity_err = bad_par;
        push = ~bad_frame & ~bad_par &
               (code != 8'hE0) & (code != 8'hF0);
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, bit counter and watchdog counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b    <= '0;
      bcnt <= '0;
      tcnt <= '0;
    end else begin
      if (state == IDLE && fall && rx_en) begin
        b    <= {ps2d, b[10:1]};
        bcnt <= 4'd9;
        tcnt <= '0;
      end else if (state == RECV) begin
        if (fall) begin
          b    <= {ps2d, b[10:1]};
          tcnt <= '0;
          if (bcnt != 4'd0)
            bcnt <= bcnt - 4'd1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

  // Prefix flags: set by E0/F0, cleared by any other outcome
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (timeout) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (state == CHECK) begin
      if (bad_frame || bad_par) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (code == 8'hE0) begin
        ext_pend <= 1'b1;
      end else if (code == 8'hF0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == DEPTH);
  assign pop      = rd_en & ~empty;
  assign wr       = push & (~full | pop);
  assign overflow = push & full & ~pop;
  assign dout     = empty ? 10'd0 : mem[rptr];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr] <= {brk_pend, ext_pend, code};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (wr && !pop)
        count <= count + 1'b1;
      else if (!wr && pop)
        count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: frames, prefixes,
// errors, FIFO overflow, watchdog and mid-frame reset.
module tb_ps2_scan_receiver;

  localparam int FL = 4;
  localparam int FD = 16;
  localparam int TO = 300;
  localparam int CW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          reset, ps2d, ps2c, rx_en, rd_en;
  logic [9:0]    dout;
  logic          empty, full;
  logic [CW-1:0] count;
  logic          parity_err, frame_err, overflow;

  int total = 0;
  int bad   = 0;
  int n_perr = 0;
  int n_ferr = 0;
  int n_ovf  = 0;
  int base_p, base_f, base_o;

  always #5 clk = ~clk;

  ps2_scan_receiver #(
    .FILTER_LEN (FL),
    .FIFO_DEPTH (FD),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2d      (ps2d),
    .ps2c      (ps2c),
    .rx_en     (rx_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always @(negedge clk) begin
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (overflow)   n_ovf++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    base_p = n_perr;
    base_f = n_ferr;
    base_o = n_ovf;
  endtask

  task automatic send_bit(input logic d, input bit pop);
    ps2d = d;
    repeat (8) @(negedge clk);
    ps2c = 1'b0;
    if (pop) begin
      repeat (5) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c,
                            input bit badp,
                            input bit pop,
                            input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^c) ^ badp, c, 1'b0};
    for (int i = 0; i < nbits; i++)
      send_bit(fr[i], pop && (i == 10));
    repeat (4) @(negedge clk);
  endtask

  task automatic pop1();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    logic [10:0] fr;
    bit got;
    reset = 1'b1;
    ps2c  = 1'b1;
    ps2d  = 1'b1;
    rx_en = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    snap();
    send_frame(8'h1C, 0, 0, 11);
    chk("make_dout",  32'(dout),  32'h01C);
    chk("make_empty", 32'(empty), 32'd0);
    chk("make_count", 32'(count), 32'd1);
    chk("make_perr",  n_perr - base_p, 0);
    chk("make_ferr",  n_ferr - base_f, 0);
    pop1();
    chk("make_pop", 32'(empty), 32'd1);

    send_frame(8'hF0, 0, 0, 11);
    chk("brk_pre_cnt", 32'(count), 32'd0);
    send_frame(8'h1C, 0, 0, 11);
    chk("brk_cnt",  32'(count), 32'd1);
    chk("brk_dout", 32'(dout),  32'h21C);
    pop1();

    send_frame(8'hE0, 0, 0, 11);
    chk("ext_pre1", 32'(count), 32'd0);
    send_frame(8'hF0, 0, 0, 11);
    chk("ext_pre2", 32'(count), 32'd0);
    send_frame(8'h75, 0, 0, 11);
    chk("extbrk_cnt",  32'(count), 32'd1);
    chk("extbrk_dout", 32'(dout),  32'h375);
    pop1();

    snap();
    send_frame(8'hF0, 0, 0, 11);
    send_frame(8'h1C, 1, 0, 11);
    chk("par_pulse", n_perr - base_p, 1);
    chk("par_ferr",  n_ferr - base_f, 0);
    chk("par_count", 32'(count), 32'd0);
    send_frame(8'hE0, 0, 0, 11);
    send_frame(8'h14, 0, 0, 11);
    chk("par_after", 32'(dout), 32'h114);
    pop1();
    chk("par_drain", 32'(empty), 32'd1);

    snap();
    for (int c = 1; c <= FD + 1; c++)
      send_frame(8'(c), 0, 0, 11);
    chk("ovf_full",  32'(full),  32'd1);
    chk("ovf_count", 32'(count), 32'(FD));
    chk("ovf_pulse", n_ovf - base_o, 1);
    chk("ovf_head",  32'(dout),  32'h001);
    snap();
    send_frame(8'h22, 0, 1, 11);
    chk("pp_count", 32'(count), 32'(FD));
    chk("pp_ovf",   n_ovf - base_o, 0);
    chk("pp_head",  32'(dout), 32'h002);
    for (int i = 0; i < FD - 1; i++)
      pop1();
    chk("pp_last", 32'(dout), 32'h022);
    pop1();
    chk("pp_drain", 32'(empty), 32'd1);

    snap();
    send_frame(8'h1C, 0, 0, 5);
    got = 0;
    for (int i = 0; i < TO + 60; i++) begin
      @(negedge clk);
      if (n_ferr != base_f) begin
        got = 1;
        break;
      end
    end
    chk("to_pulse", 32'(got), 32'd1);
    chk("to_count", 32'(count), 32'd0);
    send_frame(8'h1C, 0, 0, 11);
    chk("to_next",  32'(dout),  32'h01C);
    chk("to_ncnt",  32'(count), 32'd1);
    chk("to_nferr", n_ferr - base_f, 1);

    fr = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
    for (int i = 0; i < 4; i++)
      send_bit(fr[i], 0);
    ps2d = fr[4];
    repeat (8) @(negedge clk);
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_count", 32'(count), 32'd0);
    ps2c = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'h2A, 0, 0, 11);
    chk("mr_dout",  32'(dout),  32'h02A);
    chk("mr_ncnt",  32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
